controle_lavagem: RTL and testbench

- Washing-cycle sequencer for the washing machine top level.
- It is the initiator side of the heater start/aquecimento handshake: it drives `start` of the heater block and consumes its `aquecimento` output to detect end of heating.
- It sequences fill, optional heating, wash, rinse and spin, drives the actuators, and enforces door safety and a heater timeout.

---
 rtl/controle_lavagem_pkg.sv | 54 +++++
 rtl/controle_lavagem_temporizador.sv | 29 ++
 rtl/controle_lavagem.sv | 120 ++++++++++++
 tb/tb_controle_lavagem.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/controle_lavagem_pkg.sv
// Shared constants for the washing-machine top level: state codes, default
// phase lengths and the state-to-actuator decode used by the sequencer.
package controle_lavagem_pkg;

  typedef enum logic [2:0] {
    REPOUSO     = 3'd0,
    ENCHIMENTO  = 3'd1,
    AQUECIMENTO = 3'd2,
    LAVAGEM     = 3'd3,
    ENXAGUE     = 3'd4,
    CENTRIFUGA  = 3'd5,
    CONCLUIDO   = 3'd6,
    ERRO        = 3'd7
  } estado_t;

  localparam int PADRAO_TEMPO_ENCHIMENTO  = 4;
  localparam int PADRAO_TEMPO_LAVAGEM     = 10;
  localparam int PADRAO_TEMPO_ENXAGUE     = 6;
  localparam int PADRAO_TEMPO_CENTRIFUGA  = 8;
  localparam int PADRAO_TIMEOUT_AQUEC     = 16;
  localparam int PADRAO_TEMPO_AQUECIMENTO = 8;
  localparam int PADRAO_LARGURA           = 5;

  typedef struct packed {
    logic start_aquec;
    logic valvula;
    logic motor_lavagem;
    logic motor_centrifuga;
    logic bomba;
    logic trava_porta;
    logic fim;
    logic erro;
  } saidas_t;

  // States in which the drum holds water: door locked, timer running.
  function automatic logic estado_ativo(input estado_t e);
    return e inside {ENCHIMENTO, AQUECIMENTO, LAVAGEM, ENXAGUE, CENTRIFUGA};
  endfunction

  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s                  = '0;
    s.valvula          = (e == ENCHIMENTO) || (e == ENXAGUE);
    s.start_aquec      = (e == AQUECIMENTO);
    s.motor_lavagem    = (e == LAVAGEM) || (e == ENXAGUE);
    s.motor_centrifuga = (e == CENTRIFUGA);
    s.bomba            = (e == CENTRIFUGA);
    s.trava_porta      = estado_ativo(e);
    s.fim              = (e == CONCLUIDO);
    s.erro             = (e == ERRO);
    return s;
  endfunction

endpackage

// File: rtl/controle_lavagem_temporizador.sv
// Phase timer: counts cycles since the last clear and flags the final cycle
// of a phase of length limite. Saturates instead of wrapping.
module temporizador #(
  parameter int LARGURA = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic [LARGURA-1:0] limite,
  output logic               expira
);

  logic [LARGURA-1:0] r_contagem;

  assign expira = (r_contagem == limite - LARGURA'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (limpa) begin
      r_contagem <= '0;
    end else if (!expira) begin
      r_contagem <= r_contagem + LARGURA'(1);
    end
  end

endmodule

// File: rtl/controle_lavagem.sv
// Washing-cycle sequencer: fill, optional heating handshake, wash, rinse, spin,
// with door interlock and heater timeout. Outputs are registered state decodes.
module controle_lavagem
  import controle_lavagem_pkg::*;
#(
  parameter int TEMPO_ENCHIMENTO = PADRAO_TEMPO_ENCHIMENTO,
  parameter int TEMPO_LAVAGEM    = PADRAO_TEMPO_LAVAGEM,
  parameter int TEMPO_ENXAGUE    = PADRAO_TEMPO_ENXAGUE,
  parameter int TEMPO_CENTRIFUGA = PADRAO_TEMPO_CENTRIFUGA,
  parameter int TIMEOUT_AQUEC    = PADRAO_TIMEOUT_AQUEC,
  parameter int LARGURA          = PADRAO_LARGURA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       liga,
  input  logic       agua_quente,
  input  logic       porta_aberta,
  input  logic       aquecimento,
  output logic       start_aquec,
  output logic       valvula,
  output logic       motor_lavagem,
  output logic       motor_centrifuga,
  output logic       bomba,
  output logic       trava_porta,
  output logic       fim,
  output logic       erro,
  output logic [2:0] estado
);

  estado_t            r_estado;
  estado_t            w_proximo;
  logic               r_quente;
  logic               r_visto;
  saidas_t            r_saidas;
  logic [LARGURA-1:0] w_limite;
  logic               w_expira;
  logic               w_limpa;

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_limite = '1;
    case (r_estado)
      ENCHIMENTO:  w_limite = LARGURA'(TEMPO_ENCHIMENTO);
      AQUECIMENTO: w_limite = LARGURA'(TIMEOUT_AQUEC);
      LAVAGEM:     w_limite = LARGURA'(TEMPO_LAVAGEM);
      ENXAGUE:     w_limite = LARGURA'(TEMPO_ENXAGUE);
      CENTRIFUGA:  w_limite = LARGURA'(TEMPO_CENTRIFUGA);
      default:     w_limite = '1;
    endcase
  end

  // Door interlock is checked first so it outranks timer and handshake exits.
  always_comb begin
    w_proximo = r_estado;
    if (estado_ativo(r_estado) && porta_aberta) begin
      w_proximo = ERRO;
    end else begin
      case (r_estado)
        REPOUSO:     if (liga && !porta_aberta) w_proximo = ENCHIMENTO;
        ENCHIMENTO:  if (w_expira) w_proximo = r_quente ? AQUECIMENTO : LAVAGEM;
        AQUECIMENTO: begin
          if (r_visto && !aquecimento) w_proximo = LAVAGEM;
          else if (w_expira)           w_proximo = ERRO;
        end
        LAVAGEM:     if (w_expira) w_proximo = ENXAGUE;
        ENXAGUE:     if (w_expira) w_proximo = CENTRIFUGA;
        CENTRIFUGA:  if (w_expira) w_proximo = CONCLUIDO;
        CONCLUIDO:   w_proximo = REPOUSO;
        ERRO:        if (liga && !porta_aberta) w_proximo = REPOUSO;
        default:     w_proximo = REPOUSO;
      endcase
    end
  end

  assign w_limpa = (w_proximo != r_estado) || !estado_ativo(r_estado);

  temporizador #(
    .LARGURA (LARGURA)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .limpa  (w_limpa),
    .limite (w_limite),
    .expira (w_expira)
  );

  // NOTE: only control registers exist here, so all of them take the
  // asynchronous reset; the outputs fall to zero the moment reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= REPOUSO;
      r_quente <= 1'b0;
      r_visto  <= 1'b0;
      r_saidas <= '0;
    end else begin
      r_estado <= w_proximo;
      r_saidas <= decodifica(w_proximo);
      if (r_estado == REPOUSO && w_proximo == ENCHIMENTO) begin
        r_quente <= agua_quente;
      end
      if (w_proximo != r_estado) begin
        r_visto <= 1'b0;
      end else if (r_estado == AQUECIMENTO && aquecimento) begin
        r_visto <= 1'b1;
      end
    end
  end

  assign start_aquec      = r_saidas.start_aquec;
  assign valvula          = r_saidas.valvula;
  assign motor_lavagem    = r_saidas.motor_lavagem;
  assign motor_centrifuga = r_saidas.motor_centrifuga;
  assign bomba            = r_saidas.bomba;
  assign trava_porta      = r_saidas.trava_porta;
  assign fim              = r_saidas.fim;
  assign erro             = r_saidas.erro;
  assign estado           = r_estado;

endmodule

// File: tb/tb_controle_lavagem.sv
// Directed bench for controle_lavagem with a behavioural heater model
// (8 busy cycles after a one-cycle start latency).
module tb_controle_lavagem;

  localparam int TEMPO_AQUEC_MODELO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       liga = 1'b0;
  logic       agua_quente = 1'b0;
  logic       porta_aberta = 1'b0;
  logic       aquecimento;
  logic       start_aquec, valvula, motor_lavagem, motor_centrifuga;
  logic       bomba, trava_porta, fim, erro;
  logic [2:0] estado;
  logic [7:0] w_saidas;

  int n_verif = 0;
  int n_falhas = 0;

  logic heater_ok = 1'b1;
  logic r_aq;
  int   r_aq_cnt;

  always #5 clock = ~clock;

  controle_lavagem dut (
    .clock            (clock),
    .reset            (reset),
    .liga             (liga),
    .agua_quente      (agua_quente),
    .porta_aberta     (porta_aberta),
    .aquecimento      (aquecimento),
    .start_aquec      (start_aquec),
    .valvula          (valvula),
    .motor_lavagem    (motor_lavagem),
    .motor_centrifuga (motor_centrifuga),
    .bomba            (bomba),
    .trava_porta      (trava_porta),
    .fim              (fim),
    .erro             (erro),
    .estado           (estado)
  );

  // Heater model: busy for TEMPO_AQUEC_MODELO cycles, one cycle after start.
  always @(posedge clock or posedge reset) begin
    if (reset || !start_aquec) begin
      r_aq     <= 1'b0;
      r_aq_cnt <= 0;
    end else if (r_aq_cnt < TEMPO_AQUEC_MODELO) begin
      r_aq     <= 1'b1;
      r_aq_cnt <= r_aq_cnt + 1;
    end else begin
      r_aq <= 1'b0;
    end
  end
  assign aquecimento = heater_ok & r_aq;

  assign w_saidas = {start_aquec, valvula, motor_lavagem, motor_centrifuga,
                     bomba, trava_porta, fim, erro};

  localparam logic [7:0] S_REP = 8'b0000_0000;
  localparam logic [7:0] S_ENC = 8'b0100_0100;
  localparam logic [7:0] S_AQU = 8'b1000_0100;
  localparam logic [7:0] S_LAV = 8'b0010_0100;
  localparam logic [7:0] S_ENX = 8'b0110_0100;
  localparam logic [7:0] S_CEN = 8'b0001_1100;
  localparam logic [7:0] S_CON = 8'b0000_0010;
  localparam logic [7:0] S_ERR = 8'b0000_0001;

  typedef struct {
    logic       liga;
    logic       agua;
    logic       porta;
    int         ciclos;
    logic [2:0] estado;
    logic [7:0] saidas;
  } vetor_t;

  vetor_t tabela[19];

  task automatic check(input string nome, input logic [31:0] obtido,
                       input logic [31:0] esperado);
    n_verif++;
    if (obtido !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, obtido, esperado);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_tot, n_start, n_aq, n_est2;
    logic [2:0] apos_aquec;
    logic       viu_saida;

    // Inputs held for `ciclos` edges; outputs checked after each edge.
    tabela[0]  = '{1'b1, 1'b0, 1'b1,  2, 3'd0, S_REP}; // liga with door open
    tabela[1]  = '{1'b0, 1'b0, 1'b0,  1, 3'd0, S_REP};
    tabela[2]  = '{1'b1, 1'b0, 1'b0,  1, 3'd1, S_ENC};
    tabela[3]  = '{1'b0, 1'b0, 1'b0,  3, 3'd1, S_ENC};
    tabela[4]  = '{1'b0, 1'b0, 1'b0, 10, 3'd3, S_LAV};
    tabela[5]  = '{1'b0, 1'b0, 1'b0,  2, 3'd4, S_ENX};
    tabela[6]  = '{1'b1, 1'b0, 1'b0,  1, 3'd4, S_ENX}; // liga mid-rinse
    tabela[7]  = '{1'b0, 1'b0, 1'b0,  3, 3'd4, S_ENX};
    tabela[8]  = '{1'b0, 1'b0, 1'b0,  8, 3'd5, S_CEN};
    tabela[9]  = '{1'b0, 1'b0, 1'b0,  1, 3'd6, S_CON};
    tabela[10] = '{1'b0, 1'b0, 1'b0,  2, 3'd0, S_REP};
    tabela[11] = '{1'b1, 1'b0, 1'b0,  1, 3'd1, S_ENC};
    tabela[12] = '{1'b0, 1'b0, 1'b0,  3, 3'd1, S_ENC};
    tabela[13] = '{1'b0, 1'b0, 1'b0,  5, 3'd3, S_LAV};
    tabela[14] = '{1'b0, 1'b0, 1'b1,  1, 3'd7, S_ERR}; // door opens in wash
    tabela[15] = '{1'b1, 1'b0, 1'b1,  2, 3'd7, S_ERR};
    tabela[16] = '{1'b0, 1'b0, 1'b0,  2, 3'd7, S_ERR};
    tabela[17] = '{1'b1, 1'b0, 1'b0,  1, 3'd0, S_REP};
    tabela[18] = '{1'b0, 1'b0, 1'b0,  1, 3'd0, S_REP};

    #2;
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_saidas", 32'(w_saidas), 32'(S_REP));
    #10 reset = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      liga         = tabela[i].liga;
      agua_quente  = tabela[i].agua;
      porta_aberta = tabela[i].porta;
      for (int c = 0; c < tabela[i].ciclos; c++) begin
        tick();
        check($sformatf("vec%0d_c%0d", i, c), 32'({estado, w_saidas}),
              32'({tabela[i].estado, tabela[i].saidas}));
      end
    end
    liga = 1'b0; porta_aberta = 1'b0;

    // Hot cycle with the heater model.
    agua_quente = 1'b1; liga = 1'b1;
    tick();
    liga = 1'b0; agua_quente = 1'b0;
    n_tot = 0; n_start = 0; n_aq = 0; apos_aquec = 3'd0; viu_saida = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!(estado inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5})) break;
      n_tot++;
      if (start_aquec) n_start++;
      if (estado == 3'd2 && aquecimento) n_aq++;
      if (estado == 3'd2) begin
        check("quente_saidas_aquec", 32'(w_saidas), 32'(S_AQU));
        viu_saida = 1'b1;
      end else if (viu_saida && apos_aquec == 3'd0) begin
        apos_aquec = estado;
      end
      tick();
    end
    check("quente_start_ciclos", 32'(n_start), 32'd10);
    check("quente_aquec_ciclos", 32'(n_aq), 32'(TEMPO_AQUEC_MODELO));
    check("quente_estado_apos", 32'(apos_aquec), 32'd3);
    check("quente_total", 32'(n_tot), 32'd38);
    check("quente_fim", 32'({estado, fim}), 32'({3'd6, 1'b1}));
    tick();
    check("quente_repouso", 32'(estado), 32'd0);

    // Heater stuck: aquecimento never rises -> timeout.
    heater_ok = 1'b0;
    agua_quente = 1'b1; liga = 1'b1;
    tick();
    liga = 1'b0; agua_quente = 1'b0;
    for (int k = 0; k < 20 && estado == 3'd1; k++) tick();
    n_est2 = 0;
    for (int k = 0; k < 50 && estado == 3'd2; k++) begin
      n_est2++;
      tick();
    end
    check("timeout_ciclos", 32'(n_est2), 32'd16);
    check("timeout_estado", 32'(estado), 32'd7);
    check("timeout_erro", 32'(erro), 32'd1);
    check("timeout_start", 32'(start_aquec), 32'd0);
    liga = 1'b1;
    tick();
    liga = 1'b0;
    check("timeout_saida_erro", 32'(estado), 32'd0);
    heater_ok = 1'b1;

    // Async reset mid-spin.
    liga = 1'b1;
    tick();
    liga = 1'b0;
    for (int k = 0; k < 60 && estado != 3'd5; k++) tick();
    check("rst_chegou_centrif", 32'(estado), 32'd5);
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    check("rst_async_estado", 32'(estado), 32'd0);
    check("rst_async_saidas", 32'(w_saidas), 32'(S_REP));
    #2 reset = 1'b0;
    tick();
    check("rst_pos_repouso", 32'(estado), 32'd0);
    liga = 1'b1;
    tick();
    liga = 1'b0;
    check("rst_novo_ench", 32'(estado), 32'd1);
    tick(); tick(); tick();
    check("rst_ench_4o_ciclo", 32'(estado), 32'd1);
    tick();
    check("rst_lavagem", 32'(estado), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule
